// File: rtl/bus_hold_arbiter.sv
// Round-robin HOLD/HLDA bus arbiter sharing the 8088 local bus between the CPU and NREQ masters.
// Optional grant-length limit enabled by defining TENURE_LIMIT_EN.
module bus_hold_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned MAX_TENURE = 64,
  localparam int unsigned ID_W      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] REQ,
  input  logic            HLDA,
  output logic            HOLD,
  output logic [NREQ-1:0] GNT,
  output logic [ID_W-1:0] GNT_ID,
  output logic            ERR
);

  if (NREQ < 2 || NREQ > 8 || MAX_TENURE < 2) begin : g_param_check
    $error("bus_hold_arbiter: NREQ must be 2..8 and MAX_TENURE >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    GRANT,
    GAP,
    WAIT_REL
  } state_t;

  state_t          state_q, state_d;
  logic            hold_q, hold_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0] gnt_id_q, gnt_id_d;
  logic            err_q, err_d;
  logic [ID_W-1:0] ptr_q, ptr_d;

  logic            found;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] ptr_nxt;
  logic            take_grant;
  logic            own_req;
  logic            other_req;
  int unsigned     idx;

`ifdef TENURE_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_TENURE + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_TENURE - 1);
  logic [CNT_W-1:0] tenure_q, tenure_d;
`endif

  // Round-robin search: first set request at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
    ptr_nxt = (32'(win) == NREQ - 1) ? '0 : win + ID_W'(1);
  end

  assign own_req   = |(REQ & gnt_q);
  assign other_req = |(REQ & ~gnt_q);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    err_d      = err_q;
    ptr_d      = ptr_q;
    take_grant = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|REQ) begin
          state_d = WAIT_ACK;
          hold_d  = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (HLDA) begin
          if (found) begin
            take_grant = 1'b1;
          end else begin
            state_d = WAIT_REL;
            hold_d  = 1'b0;
          end
        end
      end
      GRANT: begin
        if (!HLDA) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          hold_d  = 1'b0;
          state_d = WAIT_REL;
        end else if (!own_req) begin
          gnt_d = '0;
          if (other_req) begin
            state_d = GAP;
          end else begin
            state_d = WAIT_REL;
            hold_d  = 1'b0;
          end
        end
`ifdef TENURE_LIMIT_EN
        else if (tenure_q == LIMIT && other_req) begin
          gnt_d   = '0;
          state_d = GAP;
        end
`endif
      end
      GAP: begin
        if (!HLDA) begin
          err_d   = 1'b1;
          gnt_d   = '0;
          hold_d  = 1'b0;
          state_d = WAIT_REL;
        end else if (found) begin
          take_grant = 1'b1;
        end else begin
          state_d = WAIT_REL;
          hold_d  = 1'b0;
        end
      end
      WAIT_REL: begin
        hold_d = 1'b0;
        if (!HLDA) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        hold_d  = 1'b0;
        gnt_d   = '0;
      end
    endcase

    if (take_grant) begin
      state_d     = GRANT;
      gnt_d       = '0;
      gnt_d[win]  = 1'b1;
      gnt_id_d    = win;
      ptr_d       = ptr_nxt;
    end
  end

`ifdef TENURE_LIMIT_EN
  // Counter saturates at the limit so a lone master keeps the bus indefinitely.
  always_comb begin
    tenure_d = tenure_q;
    if (take_grant) begin
      tenure_d = '0;
    end else if (state_q == GRANT && tenure_q != LIMIT) begin
      tenure_d = tenure_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) tenure_q <= '0;
    else       tenure_q <= tenure_d;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      hold_q   <= 1'b0;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      err_q    <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      err_q    <= err_d;
      ptr_q    <= ptr_d;
    end
  end

  assign HOLD   = hold_q;
  assign GNT    = gnt_q;
  assign GNT_ID = gnt_id_q;
  assign ERR    = err_q;

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed bench for bus_hold_arbiter: a 2-master and a 4-master instance sharing clock, reset and HLDA.
module tb_bus_hold_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       HLDA = 1'b0;
  logic [1:0] req2 = '0;
  logic [3:0] req4 = '0;

  logic       hold2, err2;
  logic [1:0] gnt2;
  logic [0:0] id2;
  logic       hold4, err4;
  logic [3:0] gnt4;
  logic [1:0] id4;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  bus_hold_arbiter #(.NREQ(2), .MAX_TENURE(8)) dut2 (
    .CLK(CLK), .RESET(RESET), .REQ(req2), .HLDA(HLDA),
    .HOLD(hold2), .GNT(gnt2), .GNT_ID(id2), .ERR(err2)
  );

  bus_hold_arbiter #(.NREQ(4), .MAX_TENURE(8)) dut4 (
    .CLK(CLK), .RESET(RESET), .REQ(req4), .HLDA(HLDA),
    .HOLD(hold4), .GNT(gnt4), .GNT_ID(id4), .ERR(err4)
  );

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    req2  = '0;
    req4  = '0;
    HLDA  = 1'b0;
    tick();
    RESET = 1'b0;
  endtask

  // {HOLD, GNT, GNT_ID, ERR} of the 2-master instance is compared as one vector.
  task automatic test_reset();
    logic [4:0] exp2;
    logic [7:0] exp4;
    apply_reset();
    exp2 = 5'b0_00_0_0;
    exp4 = 8'b0_0000_00_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++;
      $display("FAIL reset_dut2 got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    checks++;
    if ({hold4, gnt4, id4, err4} !== exp4) begin
      failures++;
      $display("FAIL reset_dut4 got=%b want=%b", {hold4, gnt4, id4, err4}, exp4);
    end
  endtask

  task automatic test_basic();
    logic [4:0] exp2;
    apply_reset();
    req2 = 2'b01;
    tick();
    exp2 = 5'b1_00_0_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL req_to_hold got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({hold2, gnt2, id2, err2} !== exp2) begin
        failures++; $display("FAIL hold_wait_ack got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
      end
    end
    HLDA = 1'b1;
    tick();
    exp2 = 5'b1_01_0_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL hlda_to_gnt got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    req2 = 2'b00;
    tick();
    exp2 = 5'b0_00_0_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL release got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    req2 = 2'b01;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({hold2, gnt2, id2, err2} !== exp2) begin
        failures++; $display("FAIL wait_rel_ignores_req got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
      end
    end
    HLDA = 1'b0;
    tick();
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL back_to_idle got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    tick();
    exp2 = 5'b1_00_0_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL idle_rerequest got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] exp2;
    apply_reset();
    req2 = 2'b11;
    tick();
    HLDA = 1'b1;
    tick();
    exp2 = 5'b1_01_0_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL b2b_first got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    req2 = 2'b10;
    tick();
    exp2 = 5'b1_00_0_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL b2b_gap got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    tick();
    exp2 = 5'b1_10_1_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL b2b_second got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    req2 = 2'b00;
    tick();
    exp2 = 5'b0_00_1_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL b2b_release got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    HLDA = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    logic [6:0] exp4;
    int m;
    apply_reset();
    req4 = 4'b1111;
    tick();
    HLDA = 1'b1;
    tick();
    for (int g = 0; g < 5; g++) begin
      m = g % 4;
      exp4 = {1'b1, 4'(1 << m), 2'(m)};
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({hold4, gnt4, id4} !== exp4) begin
          failures++; $display("FAIL fair_grant g=%0d got=%b want=%b", g, {hold4, gnt4, id4}, exp4);
        end
        if (c < 2) tick();
      end
      req4[m] = 1'b0;
      tick();
      exp4 = {1'b1, 4'b0000, 2'(m)};
      checks++;
      if ({hold4, gnt4, id4} !== exp4) begin
        failures++; $display("FAIL fair_gap g=%0d got=%b want=%b", g, {hold4, gnt4, id4}, exp4);
      end
      req4[m] = 1'b1;
      tick();
    end
    req4 = '0;
    tick();
    HLDA = 1'b0;
    tick();
  endtask

  task automatic test_withdraw();
    logic [4:0] exp2;
    apply_reset();
    req2 = 2'b01;
    tick();
    req2 = 2'b00;
    exp2 = 5'b1_00_0_0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({hold2, gnt2, id2, err2} !== exp2) begin
        failures++; $display("FAIL withdraw_hold got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
      end
      tick();
    end
    HLDA = 1'b1;
    tick();
    exp2 = 5'b0_00_0_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL withdraw_release got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    HLDA = 1'b0;
    tick();
  endtask

  task automatic test_hlda_error();
    logic [4:0] exp2;
    apply_reset();
    req2 = 2'b01;
    tick();
    HLDA = 1'b1;
    tick();
    HLDA = 1'b0;
    tick();
    exp2 = 5'b0_00_0_1;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL hlda_drop got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    tick();
    tick();
    exp2 = 5'b1_00_0_1;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL err_sticky got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    req2  = '0;
    exp2  = 5'b0_00_0_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL err_clear got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp2;
    apply_reset();
    req2 = 2'b11;
    tick();
    HLDA = 1'b1;
    tick();
    req2 = 2'b10;
    tick();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    exp2 = 5'b0_00_0_0;
    checks++;
    if ({hold2, gnt2, id2, err2} !== exp2) begin
      failures++; $display("FAIL reset_mid got=%b want=%b", {hold2, gnt2, id2, err2}, exp2);
    end
    req2 = '0;
    HLDA = 1'b0;
    tick();
  endtask

  task automatic test_tenure();
    logic [4:0] exp2;
    apply_reset();
    req2 = 2'b11;
    tick();
    HLDA = 1'b1;
    tick();
`ifdef TENURE_LIMIT_EN
    for (int r = 0; r < 3; r++) begin
      exp2 = (r % 2 == 0) ? 5'b1_01_0_0 : 5'b1_10_1_0;
      for (int c = 0; c < 8; c++) begin
        checks++;
        if ({hold2, gnt2, id2, err2} !== exp2) begin
          failures++; $display("FAIL tenure_grant r=%0d c=%0d got=%b want=%b", r, c, {hold2, gnt2, id2, err2}, exp2);
        end
        tick();
      end
      exp2 = (r % 2 == 0) ? 5'b1_00_0_0 : 5'b1_00_1_0;
      checks++;
      if ({hold2, gnt2, id2, err2} !== exp2) begin
        failures++; $display("FAIL tenure_gap r=%0d got=%b want=%b", r, {hold2, gnt2, id2, err2}, exp2);
      end
      tick();
    end
    apply_reset();
    req2 = 2'b01;
    tick();
    HLDA = 1'b1;
    tick();
`endif
    exp2 = 5'b1_01_0_0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({hold2, gnt2, id2, err2} !== exp2) begin
        failures++; $display("FAIL tenure_hold c=%0d got=%b want=%b", c, {hold2, gnt2, id2, err2}, exp2);
      end
      tick();
    end
    req2 = '0;
    tick();
    HLDA = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset();
    test_fairness();
    test_withdraw();
    test_hlda_error();
    test_reset_mid();
    test_tenure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_hold_arbiter.md
Name: bus_hold_arbiter

Overview:
- Shares the 8088 local bus between the CPU and NREQ DMA-style bus masters through the minimum-mode HOLD/HLDA handshake.
- Raises HOLD on any request and waits for HLDA.
- Issues a one-hot round-robin grant and hands the bus between masters back-to-back without releasing HOLD.
- Returns the bus to the CPU once no master is requesting.

Parameters:
- NREQ, 2, number of requesting bus masters (2..8).
- MAX_TENURE, 64, maximum grant length in cycles; used only with TENURE_LIMIT_EN.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ  input  NREQ  level request per master; held high for the whole tenure, dropped to release.
- HLDA  input  1  hold acknowledge from the processor.
- HOLD  output  1  hold request to the processor.
- GNT  output  NREQ  one-hot grant, at most one bit set.
- GNT_ID  output  clog2(NREQ) (min 1)  index of the current or last grantee.
- ERR  output  1  sticky protocol-error flag.

Behaviour:
- One clock, CLK. Reset is synchronous and active-high on RESET. All outputs are registered.
- Reset values: HOLD=0, GNT=0, GNT_ID=0, ERR=0, state=IDLE, round-robin pointer=0.
- RESET mid-operation drops HOLD and GNT on the next edge, regardless of HLDA.
- States:
  - IDLE: if |REQ sampled, go to WAIT_ACK and set HOLD=1 on that edge.
  - WAIT_ACK: HOLD=1. When HLDA is sampled high:
    - If |REQ: pick the winner, go to GRANT, and assert GNT[winner] on that edge.
    - Otherwise (requests withdrawn): go to WAIT_REL and set HOLD=0.
    - HOLD is never dropped before HLDA arrives.
  - GRANT: GNT[w] is held while REQ[w]=1. When REQ[w] is sampled 0, GNT goes to 0 on that edge, then:
    - Some other REQ bit set: go to GAP.
    - No REQ bits set: go to WAIT_REL and set HOLD=0.
  - GAP: one bus-turnaround cycle with GNT=0 and HOLD=1. On the next edge, re-arbitrate among the current REQ:
    - Winner exists: go to GRANT.
    - No requests: go to WAIT_REL with HOLD=0.
  - WAIT_REL: HOLD=0 and REQ is ignored. When HLDA is sampled 0, go to IDLE. The minimum HOLD-low time is therefore 2 cycles.
- Round robin:
  - Search starts at the pointer and wraps modulo NREQ. The first set REQ bit wins.
  - On each grant: pointer = winner+1, wrapping NREQ-1 to 0.
  - GNT_ID is updated with the winner.
- Latency:
  - REQ to HOLD: 1 cycle.
  - HLDA to GNT: 1 cycle.
  - Handoff from REQ[w] falling to GNT[next]: 2 cycles (the drop edge plus GAP).
- Simultaneous requests are resolved only by the pointer. A newly raised REQ never preempts the current grantee.
- A grantee's REQ is sampled only in GRANT. Other masters' REQ changes during GRANT have no effect until arbitration.
- HLDA falls while in GRANT or GAP:
  - ERR is set (sticky until RESET).
  - GNT=0 and HOLD=0 on the next edge.
  - State goes to WAIT_REL.

Optional Feature:
- Macro: TENURE_LIMIT_EN.
- Defined:
  - A tenure counter (clog2(MAX_TENURE+1) bits) clears on each grant and increments every GRANT cycle.
  - When the counter reaches MAX_TENURE-1 while another REQ bit is set, GNT is revoked on that edge and the state goes to GAP. The preempted master may keep REQ high and re-competes under round robin.
  - If no other master is requesting, the counter saturates and the grant continues.
- Undefined: no counter is synthesised, and a tenure ends only when its REQ drops.

Test Plan:
- Reset, then REQ=01 → HOLD=1 one cycle later. Drive HLDA=1 three cycles later → GNT=01 and GNT_ID=0 one cycle after HLDA. Drop REQ → GNT=00, HOLD=0. Drive HLDA=0 → state returns to IDLE; REQ raised in WAIT_REL produces no HOLD until then.
- REQ=11 with pointer=0 → GNT=01. Drop REQ[0] → one GAP cycle with GNT=00 and HOLD=1, then GNT=10 and GNT_ID=1 with HOLD never low. Drop REQ[1] → HOLD=0.
- Fairness, NREQ=4, REQ=1111, each master holding its grant for 3 cycles and then dropping and re-raising its REQ → grant order 0,1,2,3,0 with no master skipped.
- REQ pulses high then low before HLDA arrives → HOLD stays 1 until HLDA=1, then HOLD=0 with GNT never set.
- HLDA forced 0 mid-GRANT → ERR=1, GNT=0, HOLD=0 on the next edge. ERR persists until RESET=1 for one cycle clears all outputs.
- With TENURE_LIMIT_EN and MAX_TENURE=8: REQ=11 held continuously → GNT alternates 01/10 every 8 grant cycles plus 1 GAP. With REQ=01 alone, GNT=01 holds indefinitely.
